dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_pkg.sv | 7 +
 rtl/dmem_resp_edge_det.sv | 20 ++
 rtl/dmem_resp.sv | 70 +++++++
 tb/tb_dmem_resp.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and FSM state type for the data memory responder
package dmem_pkg;
  localparam int DATA_W = 64;
  localparam int DEPTH = 64;
  localparam int ADDR_W = $clog2(DEPTH);
  typedef enum logic {IDLE = 1'b0, DUMP = 1'b1} state_t;
endpackage

// File: rtl/dmem_resp_edge_det.sv
// edge_det: registered rising-edge detector, blind for the first cycle after reset
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);
  logic r_prev;
  logic r_armed;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_sig;
      r_armed <= 1'b1;
    end
  // a level already high at reset release is not an edge
  assign o_rise = r_armed & i_sig & ~r_prev;
endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: word memory with 1-cycle reads and a stall-the-core sequential dump
module dmem_resp #(
  parameter int N = dmem_pkg::DATA_W,
  parameter int DEPTH = dmem_pkg::DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memWrite,
  input  logic          memRead,
  input  logic [AW-1:0] address,
  input  logic [N-1:0]  writeData,
  output logic [N-1:0]  readData,
  output logic          readValid,
  output logic          busy,
  input  logic          dump,
  output logic          dumpValid,
  output logic [AW-1:0] dumpAddr,
  output logic [N-1:0]  dumpData,
  output logic          dumpDone
);
  import dmem_pkg::*;
  state_t        r_state;
  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_cnt;
  logic [N-1:0]  r_rdata;
  logic          r_rvalid;
  logic          r_done;
  logic          w_rise;
  logic          w_idle;
  logic          w_last;
  logic          w_rd;
  edge_det u_edge (.clk(clk), .rst_n(reset), .i_sig(dump), .o_rise(w_rise));
  assign w_idle = r_state == IDLE;
  assign w_last = r_cnt == AW'(DEPTH - 1);
  assign w_rd   = w_idle & memRead & ~memWrite;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_idle && memWrite) begin
      r_mem[address] <= writeData;
    end
  // counter parks on the last word so a finished dump never wraps
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= r_mem[address];
      r_done <= !w_idle && w_last;
      if (w_idle && w_rise) begin
        r_state <= DUMP;
        r_cnt   <= '0;
      end else if (!w_idle) begin
        r_state <= w_last ? IDLE : DUMP;
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
    end
  assign readData  = r_rdata;
  assign readValid = r_rvalid;
  assign busy      = !w_idle;
  assign dumpValid = !w_idle;
  assign dumpAddr  = w_idle ? '0 : r_cnt;
  assign dumpData  = w_idle ? '0 : r_mem[r_cnt];
  assign dumpDone  = r_done;
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: scoreboard bench for reads, dump sequencing and reset abort
module tb_dmem_resp;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memWrite = 1'b0;
  logic        memRead = 1'b0;
  logic [5:0]  address = '0;
  logic [63:0] writeData = '0;
  logic [63:0] readData;
  logic        readValid;
  logic        busy;
  logic        dump = 1'b0;
  logic        dumpValid;
  logic [5:0]  dumpAddr;
  logic [63:0] dumpData;
  logic        dumpDone;
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  bit          dump_on = 1'b1;
  logic [63:0] model [64];
  logic [63:0] rq[$];
  logic [5:0]  da[$];
  logic [63:0] dd[$];

  dmem_resp dut (
    .clk(clk), .reset(reset), .memWrite(memWrite), .memRead(memRead),
    .address(address), .writeData(writeData), .readData(readData),
    .readValid(readValid), .busy(busy), .dump(dump), .dumpValid(dumpValid),
    .dumpAddr(dumpAddr), .dumpData(dumpData), .dumpDone(dumpDone)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
    if (dumpDone) done_cnt++;
    if (readValid) begin
      if (rq.size() == 0) check("rd_unexpected", 64'(readValid), 64'd0);
      else check("rd_data", readData, rq.pop_front());
    end
    if (dumpValid && dump_on) begin
      if (da.size() == 0) check("dump_unexpected", 64'(dumpValid), 64'd0);
      else begin
        check("dump_addr", 64'(dumpAddr), 64'(da.pop_front()));
        check("dump_data", dumpData, dd.pop_front());
      end
    end
  endtask

  task automatic op(input logic rd, input logic wr, input logic [5:0] a, input logic [63:0] d);
    memRead = rd;
    memWrite = wr;
    address = a;
    writeData = d;
    if (wr) model[a] = d;
    else if (rd) rq.push_back(model[a]);
    tick();
    memRead = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic push_dump();
    for (int i = 0; i < 64; i++) begin
      da.push_back(6'(i));
      dd.push_back(model[i]);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 200) begin
      tick();
      n++;
    end
    check("dump_done_seen", 64'(done_cnt), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdata"}, readData, 64'd0);
    check({tag, "_rvalid"}, 64'(readValid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_dvalid"}, 64'(dumpValid), 64'd0);
    check({tag, "_daddr"}, 64'(dumpAddr), 64'd0);
    check({tag, "_ddata"}, dumpData, 64'd0);
    check({tag, "_ddone"}, 64'(dumpDone), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) model[i] = '0;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b1;
    tick();
    // write then read-after-write
    op(1'b0, 1'b1, 6'd5, 64'hDEADBEEF);
    op(1'b1, 1'b0, 6'd5, 64'd0);
    tick();
    check("rvalid_idle", 64'(readValid), 64'd0);
    check("rdata_hold", readData, 64'hDEADBEEF);
    // simultaneous read+write: write wins, no read response
    op(1'b1, 1'b1, 6'd3, 64'h11);
    check("rw_rvalid", 64'(readValid), 64'd0);
    op(1'b1, 1'b0, 6'd3, 64'd0);
    // fill and dump
    for (int i = 0; i < 64; i++) op(1'b0, 1'b1, 6'(i), 64'(i));
    busy_cnt = 0;
    done_cnt = 0;
    push_dump();
    dump = 1'b1;
    tick();
    dump = 1'b0;
    wait_done();
    check("dump_busy_cycles", 64'(busy_cnt), 64'd64);
    check("dump_q_empty", 64'(da.size()), 64'd0);
    // dump held high: one pass only
    busy_cnt = 0;
    done_cnt = 0;
    push_dump();
    dump = 1'b1;
    for (int i = 0; i < 200; i++) tick();
    dump = 1'b0;
    tick();
    check("hold_done_cnt", 64'(done_cnt), 64'd1);
    check("hold_busy_cycles", 64'(busy_cnt), 64'd64);
    check("hold_q_empty", 64'(da.size()), 64'd0);
    // write on the dump edge lands; writes/reads during dump are ignored
    op(1'b0, 1'b1, 6'd0, 64'hA5);
    busy_cnt = 0;
    done_cnt = 0;
    memWrite = 1'b1;
    address = 6'd1;
    writeData = 64'h1234;
    model[1] = 64'h1234;
    push_dump();
    dump = 1'b1;
    tick();
    dump = 1'b0;
    memWrite = 1'b1;
    memRead = 1'b1;
    address = 6'd0;
    writeData = 64'hFF;
    tick();
    check("busy_during_dump", 64'(busy), 64'd1);
    check("rvalid_during_dump", 64'(readValid), 64'd0);
    memWrite = 1'b0;
    memRead = 1'b0;
    wait_done();
    op(1'b1, 1'b0, 6'd0, 64'd0);
    op(1'b1, 1'b0, 6'd1, 64'd0);
    // reset in the middle of a dump
    dump_on = 1'b0;
    dump = 1'b1;
    tick();
    dump = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("busy_before_abort", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check_zero("abort");
    da.delete();
    dd.delete();
    for (int i = 0; i < 64; i++) model[i] = '0;
    done_cnt = 0;
    dump = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) tick();
    check("no_dump_at_release", 64'(busy_cnt), 64'd0);
    check("no_done_after_abort", 64'(done_cnt), 64'd0);
    dump = 1'b0;
    dump_on = 1'b1;
    tick();
    op(1'b1, 1'b0, 6'd0, 64'd0);
    op(1'b1, 1'b0, 6'd5, 64'd0);
    op(1'b1, 1'b0, 6'd3, 64'd0);
    op(1'b1, 1'b0, 6'd63, 64'd0);
    check("rd_q_empty", 64'(rq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
